regfile_wb_arbiter: RTL

Shares the single write port of the 32x32 register file between NUM_REQ writeback requesters (ALU, load unit, mul/div unit) using a valid/ready handshake and round-robin arbitration. It drives the register file write controls from a one-stage registered output. It also keeps a 32-entry pending-write scoreboard, so decode can detect read-after-write hazards on rs/rt.

---
 rtl/regfile_wb_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/regfile_wb_arbiter.sv
// Register-file writeback arbiter: round-robin sharing of the single write port
// among NUM_REQ valid/ready requesters, one-stage registered write controls, and a
// 32-entry pending-write scoreboard for read-after-write hazard detection.
// Optional build macro: REGWB_LED_EN adds reg_led_o, the low byte of the last
// enabled write, for board debug.

// Per-requester lane: passes its request through only when granted, so the
// selected request is an OR of all lanes.
module regfile_wb_lane #(
  parameter int REG_W  = 5,
  parameter int DATA_W = 32
) (
  input  logic              sel,
  input  logic [REG_W-1:0]  reg_in,
  input  logic [DATA_W-1:0] data_in,
  output logic [REG_W-1:0]  reg_out,
  output logic [DATA_W-1:0] data_out
);
  assign reg_out  = sel ? reg_in  : '0;
  assign data_out = sel ? data_in : '0;
endmodule

module regfile_wb_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int REG_W   = 5,
  parameter int DATA_W  = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*REG_W-1:0]  req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic                      issue_valid,
  input  logic [REG_W-1:0]          issue_reg,
  input  logic [REG_W-1:0]          rs_query,
  input  logic [REG_W-1:0]          rt_query,
  output logic                      hazard_o,
  output logic [31:0]               busy_o,
  output logic                      regwrite_ctrl,
  output logic [REG_W-1:0]          write_register,
  output logic [DATA_W-1:0]         write_data
`ifdef REGWB_LED_EN
  ,
  output logic [7:0]                reg_led_o
`endif
);
  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NUM_REQ - 1);

  logic [PTR_W-1:0]                    ptr;
  logic [PTR_W-1:0]                    gidx;
  logic [PTR_W-1:0]                    cur;
  logic [NUM_REQ-1:0]                  grant;
  logic                                hs;
  logic [NUM_REQ-1:0][REG_W-1:0]       lane_reg;
  logic [NUM_REQ-1:0][DATA_W-1:0]      lane_data;
  logic [REG_W-1:0]                    sel_reg;
  logic [DATA_W-1:0]                   sel_data;
  logic [31:0]                         busy_q;
  logic [31:0]                         busy_d;

  // Round-robin search from the pointer, wrapping; first valid requester wins.
  // Nothing is granted while reset is asserted.
  always_comb begin
    grant = '0;
    gidx  = '0;
    hs    = 1'b0;
    cur   = ptr;
    if (rst_n) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        if (!hs && req_valid[cur]) begin
          grant[cur] = 1'b1;
          gidx       = cur;
          hs         = 1'b1;
        end
        cur = (cur == LAST) ? '0 : cur + 1'b1;
      end
    end
  end

  assign req_ready = grant;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    regfile_wb_lane #(.REG_W(REG_W), .DATA_W(DATA_W)) u_lane (
      .sel      (grant[i]),
      .reg_in   (req_reg[i*REG_W +: REG_W]),
      .data_in  (req_data[i*DATA_W +: DATA_W]),
      .reg_out  (lane_reg[i]),
      .data_out (lane_data[i])
    );
  end

  // Grant is one-hot, so OR-ing the masked lanes selects the winner.
  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_reg  |= lane_reg[i];
      sel_data |= lane_data[i];
    end
  end

  // Pointer moves to the slot after the winner; holds when nothing completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  ptr <= '0;
    else if (hs) ptr <= (gidx == LAST) ? '0 : gidx + 1'b1;
  end

  // Scoreboard next state: clear on writeback, then set on issue so a newer
  // producer of the same register keeps it busy. r0 is never busy.
  always_comb begin
    busy_d = busy_q;
    if (hs && sel_reg != '0)               busy_d[sel_reg]   = 1'b0;
    if (issue_valid && issue_reg != '0)    busy_d[issue_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  assign busy_o   = busy_q;
  assign hazard_o = busy_q[rs_query] | busy_q[rt_query];

  // Registered write port; r0 writes are accepted but never enabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      regwrite_ctrl  <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else begin
      regwrite_ctrl <= hs && (sel_reg != '0);
      if (hs) begin
        write_register <= sel_reg;
        write_data     <= sel_data;
      end
    end
  end

`ifdef REGWB_LED_EN
  // Debug LEDs capture the low byte of each committed write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)             reg_led_o <= '0;
    else if (regwrite_ctrl) reg_led_o <= write_data[7:0];
  end
`endif

endmodule
